hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage WISC core. It is the successor of the phase-2 combinational hazard detector.
- Covers load-to-use, branch flag and branch-register RAW hazards, selectable per FWD_EN.
- Adds multi-cycle I-cache/D-cache miss freeze with a registered FSM.
- Tracks a redirect that arrives during an I-miss and holds it pending.
- Provides saturating stall/flush performance counters.
- Sits in ID, driving the write-enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
REG_W, 4, register index width; index 0 is the hardwired zero register and never causes a hazard
FLAG_W, 3, flag-enable vector width, indexed by FLAG_Z/FLAG_V/FLAG_N from common/flags.vh
FWD_EN, 1, 1 = EX/MEM forwarding exists (ALU RAW needs no stall); 0 = stall on any RAW against id_ex/ex_mem
CNT_W, 16, performance counter width

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_ex_mem_read  in  1  load in EX
id_ex_reg_write  in  1  EX instruction writes rd
ex_mem_reg_write  in  1  MEM instruction writes rd
id_ex_rd  in  REG_W  EX destination register
ex_mem_rd  in  REG_W  MEM destination register
if_id_rs  in  REG_W  ID source rs
if_id_rt  in  REG_W  ID source rt
if_id_uses_rt  in  1  ID instruction actually reads rt (0 for SW data path, immediates)
if_id_branch  in  1  B in ID
if_id_branchr  in  1  BR in ID
if_id_cond  in  3  branch condition code
id_ex_flag_en  in  FLAG_W  flags written by EX instruction
ex_mem_flag_en  in  FLAG_W  flags written by MEM instruction
branch_taken  in  1  ID branch resolved taken (valid only when unstalled)
icache_miss  in  1  level, I-cache busy
dcache_miss  in  1  level, D-cache busy
pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1 each  stage write enables
if_id_flush  out  1  load NOP into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
redirect  out  1  PC mux selects branch target
redirect_pending  out  1  registered; discard next fetched word after I-miss
state  out  2  00 RUN, 01 IMISS, 10 DMISS
stall_cycles  out  CNT_W  saturating count of cycles with pc_wen=0
flush_count  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Condition flag reads:
  - 000 and 001 read Z.
  - 011 reads N.
  - 010, 100 and 101 read Z and N.
  - 110 reads V.
  - 111 reads none.
- br_flag_haz: branch or branchr is high, and (id_ex_flag_en | ex_mem_flag_en) overlaps the read set.
- br_reg_haz: branchr is high, and rs equals a nonzero id_ex_rd with id_ex_reg_write, or a nonzero ex_mem_rd with ex_mem_reg_write.
- l2u_haz: id_ex_mem_read is high, id_ex_rd is nonzero, and (rs==id_ex_rd or (if_id_uses_rt and rt==id_ex_rd)).
- raw_haz: zero when FWD_EN=1. When FWD_EN=0, it is the same test as l2u_haz but against both id_ex_rd (with id_ex_reg_write) and ex_mem_rd (with ex_mem_reg_write).
- data_stall = l2u_haz | br_flag_haz | br_reg_haz | raw_haz. It is an OR of all terms; any one term stalls.
- Priority, evaluated combinationally each cycle:
  1. dcache_miss: all five wen = 0, no flush, redirect = 0.
  2. data_stall: pc_wen = if_id_wen = 0, id_ex_flush = 1, redirect = 0.
  3. taken branch: redirect = 1, if_id_flush = 1, pc_wen = 1.
  4. icache_miss without a taken branch: pc_wen = 0, if_id_flush = 1; downstream stages advance.
  5. Otherwise: all wen = 1, flushes = 0.
- Taken branch during an icache miss: redirect = 1, and redirect_pending is set at the next edge.
- redirect_pending clears on the first cycle in RUN with icache_miss = 0 and pc_wen = 1. That cycle also asserts if_id_flush.
- FSM, registered, next-state priority DMISS > IMISS > RUN:
  - RUN -> DMISS on dcache_miss; RUN -> IMISS on icache_miss.
  - IMISS -> DMISS if dcache_miss; IMISS -> RUN when icache_miss = 0.
  - DMISS -> IMISS when dcache_miss = 0 and icache_miss = 1; DMISS -> RUN when both are 0.
- Freeze outputs use the live miss inputs (zero-latency). state is informational, 1-cycle delayed.
- stall_cycles increments every cycle pc_wen = 0; flush_count increments every cycle redirect = 1. Both hold at 2^CNT_W-1.
- Reset (rst_n = 0 at a clock edge):
  - state = RUN, redirect_pending = 0, counters = 0.
  - Combinational outputs during reset: all wen = 1, flushes = 0, redirect = 0.
  - Reset mid-miss aborts any pending redirect.

Test Plan:
- LW R3 in EX, ADD R4,R3,R5 in ID -> exactly 1 cycle pc_wen = 0, if_id_wen = 0, id_ex_flush = 1; stall_cycles goes 0->1.
- SW R3 in ID (uses_rt = 0, rs = R2), LW R3 in EX -> no stall. Same with id_ex_rd = 0 -> no stall.
- Flag stall by condition:
  - ADD (flag_en Z,V,N) in EX, B cond 000 in ID -> stall 2 cycles (EX, then MEM), then redirect = 1 when taken; flush_count = 1.
  - cond 111 -> no stall.
  - cond 110 with flag_en = Z only -> no stall.
- FWD_EN = 0: ADD R1 in MEM, SUB using R1 in ID -> 1-cycle stall. With FWD_EN = 1 -> no stall.
- dcache_miss held for 5 cycles while a load-to-use hazard is present -> all wen = 0 for 5 cycles; state reads DMISS at cycles 2-6; then the 1-cycle l2u stall follows.
- icache_miss held for 4 cycles, taken branch at cycle 2 -> redirect = 1 at cycle 2, redirect_pending = 1 for cycles 3-5, if_id_flush on the first RUN cycle, then pending = 0. Reset asserted at cycle 3 -> pending = 0 and state = RUN next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage WISC core: data/branch stalls,
// cache-miss freeze FSM, pending redirect tracking and performance counters.
module hazard_ctrl #(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned FLAG_W = 3,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_reg_write,
  input  logic              ex_mem_reg_write,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic [REG_W-1:0]  if_id_rs,
  input  logic [REG_W-1:0]  if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic              if_id_branch,
  input  logic              if_id_branchr,
  input  logic [2:0]        if_id_cond,
  input  logic [FLAG_W-1:0] id_ex_flag_en,
  input  logic [FLAG_W-1:0] ex_mem_flag_en,
  input  logic              branch_taken,
  input  logic              icache_miss,
  input  logic              dcache_miss,
  output logic              pc_wen,
  output logic              if_id_wen,
  output logic              id_ex_wen,
  output logic              ex_mem_wen,
  output logic              mem_wb_wen,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              redirect,
  output logic              redirect_pending,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  // Bit positions of the condition flags inside the flag-enable vectors.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IMISS = 2'b01,
    DMISS = 2'b10
  } state_t;

  state_t state_r;
  state_t state_nxt;

  logic [FLAG_W-1:0] flag_reads;
  logic              l2u_haz;
  logic              raw_haz;
  logic              br_flag_haz;
  logic              br_reg_haz;
  logic              data_stall;
  logic              taken;
  logic              run_ok;
  logic              pend_clr;

  function automatic logic [FLAG_W-1:0] cond_reads(input logic [2:0] cond);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (cond)
      3'b000, 3'b001: m[FLAG_Z] = 1'b1;
      3'b011:         m[FLAG_N] = 1'b1;
      3'b010, 3'b100, 3'b101: begin
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      3'b110:         m[FLAG_V] = 1'b1;
      default:        m = '0;
    endcase
    return m;
  endfunction

  // True when the ID instruction sources a nonzero register that rd writes.
  function automatic logic reads_reg(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
    return (rd != '0) && ((rs == rd) || (uses_rt && (rt == rd)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign flag_reads  = cond_reads(if_id_cond);
  assign br_flag_haz = (if_id_branch | if_id_branchr) &
                       (|((id_ex_flag_en | ex_mem_flag_en) & flag_reads));
  assign br_reg_haz  = if_id_branchr &
                       ((id_ex_reg_write  & reads_reg(id_ex_rd,  if_id_rs, if_id_rt, 1'b0)) |
                        (ex_mem_reg_write & reads_reg(ex_mem_rd, if_id_rs, if_id_rt, 1'b0)));
  assign l2u_haz     = id_ex_mem_read &
                       reads_reg(id_ex_rd, if_id_rs, if_id_rt, if_id_uses_rt);

  if (FWD_EN) begin : g_fwd
    assign raw_haz = 1'b0;
  end else begin : g_no_fwd
    assign raw_haz =
      (id_ex_reg_write  & reads_reg(id_ex_rd,  if_id_rs, if_id_rt, if_id_uses_rt)) |
      (ex_mem_reg_write & reads_reg(ex_mem_rd, if_id_rs, if_id_rt, if_id_uses_rt));
  end

  assign data_stall = l2u_haz | br_flag_haz | br_reg_haz | raw_haz;
  assign taken      = branch_taken & (if_id_branch | if_id_branchr);

  // The fetch path is genuinely advancing again: this is where a redirect
  // held across an I-miss gets its stale fetched word discarded.
  assign run_ok   = ~dcache_miss & ~data_stall & ~icache_miss;
  assign pend_clr = redirect_pending & run_ok;

  always_comb begin
    pc_wen      = 1'b1;
    if_id_wen   = 1'b1;
    id_ex_wen   = 1'b1;
    ex_mem_wen  = 1'b1;
    mem_wb_wen  = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    redirect    = 1'b0;
    if (rst_n) begin
      if (dcache_miss) begin
        pc_wen     = 1'b0;
        if_id_wen  = 1'b0;
        id_ex_wen  = 1'b0;
        ex_mem_wen = 1'b0;
        mem_wb_wen = 1'b0;
      end else if (data_stall) begin
        pc_wen      = 1'b0;
        if_id_wen   = 1'b0;
        id_ex_flush = 1'b1;
      end else if (taken) begin
        redirect    = 1'b1;
        if_id_flush = 1'b1;
      end else if (icache_miss) begin
        pc_wen      = 1'b0;
        if_id_flush = 1'b1;
      end
      if (pend_clr) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      RUN: begin
        if (dcache_miss)      state_nxt = DMISS;
        else if (icache_miss) state_nxt = IMISS;
      end
      IMISS: begin
        if (dcache_miss)       state_nxt = DMISS;
        else if (!icache_miss) state_nxt = RUN;
      end
      DMISS: begin
        if (!dcache_miss) state_nxt = icache_miss ? IMISS : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign state = state_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_pending <= 1'b0;
    end else if (redirect && icache_miss) begin
      redirect_pending <= 1'b1;
    end else if (pend_clr) begin
      redirect_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_wen) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if (redirect) begin
        flush_count <= sat_inc(flush_count);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (no forwarding / forwarding with a
// narrow counter) compared every cycle against a rule-level model.
module tb_hazard_ctrl;

  localparam int CNT_W0 = 16;
  localparam int CNT_W1 = 5;
  localparam int CMAX0  = 65535;
  localparam int CMAX1  = 31;

  localparam logic [2:0] FZ = 3'b001;
  localparam logic [2:0] FV = 3'b010;
  localparam logic [2:0] FN = 3'b100;
  localparam logic [2:0] READ_TBL [8] = '{FZ, FZ, FZ | FN, FN, FZ | FN, FZ | FN, FV, 3'b000};

  logic       clk;
  logic       rst_n;
  logic       id_ex_mem_read, id_ex_reg_write, ex_mem_reg_write;
  logic [3:0] id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
  logic       if_id_uses_rt, if_id_branch, if_id_branchr;
  logic [2:0] if_id_cond, id_ex_flag_en, ex_mem_flag_en;
  logic       branch_taken, icache_miss, dcache_miss;

  logic pc_wen0, if_id_wen0, id_ex_wen0, ex_mem_wen0, mem_wb_wen0;
  logic if_id_flush0, id_ex_flush0, redirect0, pend0;
  logic [1:0] state0;
  logic [CNT_W0-1:0] stall0, flush0;
  logic pc_wen1, if_id_wen1, id_ex_wen1, ex_mem_wen1, mem_wb_wen1;
  logic if_id_flush1, id_ex_flush1, redirect1, pend1;
  logic [1:0] state1;
  logic [CNT_W1-1:0] stall1, flush1;

  hazard_ctrl #(.REG_W(4), .FLAG_W(3), .FWD_EN(1'b0), .CNT_W(CNT_W0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
    .ex_mem_reg_write(ex_mem_reg_write), .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .if_id_branch(if_id_branch), .if_id_branchr(if_id_branchr), .if_id_cond(if_id_cond),
    .id_ex_flag_en(id_ex_flag_en), .ex_mem_flag_en(ex_mem_flag_en),
    .branch_taken(branch_taken), .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .pc_wen(pc_wen0), .if_id_wen(if_id_wen0), .id_ex_wen(id_ex_wen0),
    .ex_mem_wen(ex_mem_wen0), .mem_wb_wen(mem_wb_wen0),
    .if_id_flush(if_id_flush0), .id_ex_flush(id_ex_flush0), .redirect(redirect0),
    .redirect_pending(pend0), .state(state0),
    .stall_cycles(stall0), .flush_count(flush0)
  );

  hazard_ctrl #(.REG_W(4), .FLAG_W(3), .FWD_EN(1'b1), .CNT_W(CNT_W1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
    .ex_mem_reg_write(ex_mem_reg_write), .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .if_id_branch(if_id_branch), .if_id_branchr(if_id_branchr), .if_id_cond(if_id_cond),
    .id_ex_flag_en(id_ex_flag_en), .ex_mem_flag_en(ex_mem_flag_en),
    .branch_taken(branch_taken), .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .pc_wen(pc_wen1), .if_id_wen(if_id_wen1), .id_ex_wen(id_ex_wen1),
    .ex_mem_wen(ex_mem_wen1), .mem_wb_wen(mem_wb_wen1),
    .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1), .redirect(redirect1),
    .redirect_pending(pend1), .state(state1),
    .stall_cycles(stall1), .flush_count(flush1)
  );

  // Bit order: pc, if_id, id_ex, ex_mem, mem_wb wen, if_id_flush, id_ex_flush, redirect
  logic [7:0]  comb_o  [2];
  logic        pend_o  [2];
  logic [1:0]  st_o    [2];
  logic [15:0] stall_o [2];
  logic [15:0] flush_o [2];

  assign comb_o[0]  = {pc_wen0, if_id_wen0, id_ex_wen0, ex_mem_wen0, mem_wb_wen0,
                       if_id_flush0, id_ex_flush0, redirect0};
  assign comb_o[1]  = {pc_wen1, if_id_wen1, id_ex_wen1, ex_mem_wen1, mem_wb_wen1,
                       if_id_flush1, id_ex_flush1, redirect1};
  assign pend_o[0]  = pend0;
  assign pend_o[1]  = pend1;
  assign st_o[0]    = state0;
  assign st_o[1]    = state1;
  assign stall_o[0] = stall0;
  assign stall_o[1] = {11'b0, stall1};
  assign flush_o[0] = flush0;
  assign flush_o[1] = {11'b0, flush1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_stall(input bit fwd);
    logic [3:0] src [2];
    bit         use_src [2];
    bit         s;
    src[0] = if_id_rs;
    src[1] = if_id_rt;
    use_src[0] = 1'b1;
    use_src[1] = if_id_uses_rt;
    s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (use_src[k] && src[k] != 4'd0) begin
        if (id_ex_mem_read && src[k] == id_ex_rd) s = 1'b1;
        if (!fwd && id_ex_reg_write && src[k] == id_ex_rd) s = 1'b1;
        if (!fwd && ex_mem_reg_write && src[k] == ex_mem_rd) s = 1'b1;
      end
    end
    if (if_id_branchr && if_id_rs != 4'd0) begin
      if (id_ex_reg_write && if_id_rs == id_ex_rd) s = 1'b1;
      if (ex_mem_reg_write && if_id_rs == ex_mem_rd) s = 1'b1;
    end
    if ((if_id_branch || if_id_branchr) &&
        (((id_ex_flag_en | ex_mem_flag_en) & READ_TBL[if_id_cond]) != 3'b000)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [7:0] model_comb(input bit fwd, input bit pend);
    logic [7:0] e;
    bit         tk;
    tk = branch_taken && (if_id_branch || if_id_branchr);
    if (!rst_n)               e = 8'b11111_000;
    else if (dcache_miss)     e = 8'b00000_000;
    else if (model_stall(fwd)) e = 8'b00111_010;
    else if (tk)              e = 8'b11111_101;
    else if (icache_miss)     e = 8'b01111_100;
    else                      e = 8'b11111_000;
    if (rst_n && pend && !icache_miss && e[7]) e[2] = 1'b1;
    return e;
  endfunction

  int         m_stall [2] = '{0, 0};
  int         m_flush [2] = '{0, 0};
  bit         m_pend  [2] = '{1'b0, 1'b0};
  logic [1:0] m_st = 2'b00;

  always @(negedge clk) begin
    logic [7:0] e;
    int         cmax;
    for (int d = 0; d < 2; d++) begin
      cmax = (d == 1) ? CMAX1 : CMAX0;
      e = model_comb(d == 1, m_pend[d]);
      check($sformatf("comb_d%0d", d), 32'(comb_o[d]), 32'(e));
      check($sformatf("pending_d%0d", d), 32'(pend_o[d]), 32'(m_pend[d]));
      check($sformatf("state_d%0d", d), 32'(st_o[d]), 32'(m_st));
      check($sformatf("stall_cycles_d%0d", d), 32'(stall_o[d]), 32'(m_stall[d]));
      check($sformatf("flush_count_d%0d", d), 32'(flush_o[d]), 32'(m_flush[d]));
      if (!rst_n) begin
        m_pend[d]  <= 1'b0;
        m_stall[d] <= 0;
        m_flush[d] <= 0;
      end else begin
        if (e[0] && icache_miss) m_pend[d] <= 1'b1;
        else if (m_pend[d] && !icache_miss && e[7]) m_pend[d] <= 1'b0;
        if (!e[7] && m_stall[d] < cmax) m_stall[d] <= m_stall[d] + 1;
        if (e[0] && m_flush[d] < cmax) m_flush[d] <= m_flush[d] + 1;
      end
    end
    m_st <= !rst_n ? 2'b00 : dcache_miss ? 2'b10 : icache_miss ? 2'b01 : 2'b00;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0; ex_mem_reg_write = 1'b0;
    id_ex_rd = 4'd0; ex_mem_rd = 4'd0; if_id_rs = 4'd0; if_id_rt = 4'd0;
    if_id_uses_rt = 1'b0; if_id_branch = 1'b0; if_id_branchr = 1'b0;
    if_id_cond = 3'd0; id_ex_flag_en = 3'd0; ex_mem_flag_en = 3'd0;
    branch_taken = 1'b0; icache_miss = 1'b0; dcache_miss = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_l2u();
    id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_rd = 4'd3;
    if_id_rs = 4'd3; if_id_rt = 4'd5; if_id_uses_rt = 1'b1;
  endtask

  initial begin
    bit im, dm;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall_cycles", 32'(stall1), 32'd0);
    check("rst_state", 32'(state1), 32'd0);
    check("rst_pending", 32'(pend1), 32'd0);

    // LW R3 in EX, ADD R4,R3,R5 in ID
    cyc(); set_l2u();
    @(negedge clk);
    check("l2u_pc_wen", 32'(pc_wen1), 32'd0);
    check("l2u_if_id_wen", 32'(if_id_wen1), 32'd0);
    check("l2u_id_ex_flush", 32'(id_ex_flush1), 32'd1);
    cyc(); idle();
    @(negedge clk);
    check("l2u_stall_cnt_d1", 32'(stall1), 32'd1);
    check("l2u_stall_cnt_d0", 32'(stall0), 32'd1);

    // SW R3 with rs=R2, and load to R0: no stall
    cyc(); idle();
    id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; id_ex_rd = 4'd3;
    if_id_rs = 4'd2; if_id_rt = 4'd3; if_id_uses_rt = 1'b0;
    @(negedge clk);
    check("sw_no_stall_d1", 32'(pc_wen1), 32'd1);
    check("sw_no_stall_d0", 32'(pc_wen0), 32'd1);
    cyc(); idle();
    id_ex_mem_read = 1'b1; id_ex_reg_write = 1'b1; if_id_uses_rt = 1'b1;
    @(negedge clk);
    check("rd0_no_stall", 32'(pc_wen1), 32'd1);

    // ADD sets Z,V,N; B cond 000 waits through EX and MEM, then redirects
    cyc(); idle();
    if_id_branch = 1'b1; id_ex_flag_en = 3'b111; id_ex_reg_write = 1'b1; id_ex_rd = 4'd6;
    @(negedge clk);
    check("flag_stall_ex", 32'(pc_wen1), 32'd0);
    cyc(); idle();
    if_id_branch = 1'b1; ex_mem_flag_en = 3'b111; ex_mem_reg_write = 1'b1; ex_mem_rd = 4'd6;
    @(negedge clk);
    check("flag_stall_mem", 32'(pc_wen1), 32'd0);
    cyc(); idle();
    if_id_branch = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    check("branch_redirect", 32'(redirect1), 32'd1);
    check("branch_if_id_flush", 32'(if_id_flush1), 32'd1);
    cyc(); idle();
    @(negedge clk);
    check("flush_count_1", 32'(flush1), 32'd1);
    check("stall_cnt_3_d1", 32'(stall1), 32'd3);
    check("stall_cnt_3_d0", 32'(stall0), 32'd3);

    cyc(); idle();
    if_id_branch = 1'b1; if_id_cond = 3'b111; id_ex_flag_en = 3'b111;
    @(negedge clk);
    check("cond111_no_stall", 32'(pc_wen1), 32'd1);
    cyc(); idle();
    if_id_branch = 1'b1; if_id_cond = 3'b110; id_ex_flag_en = FZ;
    @(negedge clk);
    check("cond110_z_no_stall", 32'(pc_wen1), 32'd1);

    // ADD R1 in MEM, SUB using R1 in ID
    cyc(); idle();
    ex_mem_reg_write = 1'b1; ex_mem_rd = 4'd1; if_id_rs = 4'd1; if_id_rt = 4'd2; if_id_uses_rt = 1'b1;
    @(negedge clk);
    check("raw_nofwd_stall", 32'(pc_wen0), 32'd0);
    check("raw_fwd_no_stall", 32'(pc_wen1), 32'd1);

    // D-miss for 5 cycles over a load-to-use hazard
    for (int i = 0; i < 5; i++) begin
      cyc(); idle(); set_l2u(); dcache_miss = 1'b1;
      @(negedge clk);
      check("dmiss_wen", 32'(comb_o[1][7:3]), 32'd0);
      if (i >= 1) check("dmiss_state", 32'(state1), 32'd2);
    end
    cyc(); idle(); set_l2u();
    @(negedge clk);
    check("post_dmiss_l2u", 32'(pc_wen1), 32'd0);
    check("post_dmiss_flush", 32'(id_ex_flush1), 32'd1);
    check("post_dmiss_state", 32'(state1), 32'd2);
    cyc(); idle();
    @(negedge clk);
    check("dmiss_done_state", 32'(state1), 32'd0);

    // I-miss for 4 cycles with a taken branch in the second
    cyc(); idle(); icache_miss = 1'b1;
    @(negedge clk);
    check("imiss_pc_wen", 32'(pc_wen1), 32'd0);
    check("imiss_if_id_flush", 32'(if_id_flush1), 32'd1);
    cyc(); idle(); icache_miss = 1'b1; if_id_branch = 1'b1; if_id_cond = 3'b111; branch_taken = 1'b1;
    @(negedge clk);
    check("imiss_redirect", 32'(redirect1), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); icache_miss = 1'b1;
      @(negedge clk);
      check("imiss_pending", 32'(pend1), 32'd1);
    end
    cyc(); idle();
    @(negedge clk);
    check("pending_last", 32'(pend1), 32'd1);
    check("pending_discard_flush", 32'(if_id_flush1), 32'd1);
    check("pending_pc_wen", 32'(pc_wen1), 32'd1);
    check("pending_state_imiss", 32'(state1), 32'd1);
    cyc(); idle();
    @(negedge clk);
    check("pending_cleared", 32'(pend1), 32'd0);
    check("imiss_done_state", 32'(state1), 32'd0);

    // Reset arriving mid-miss drops the pending redirect
    cyc(); idle(); icache_miss = 1'b1;
    cyc(); idle(); icache_miss = 1'b1; if_id_branch = 1'b1; if_id_cond = 3'b111; branch_taken = 1'b1;
    cyc(); idle(); icache_miss = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_pending_before", 32'(pend1), 32'd1);
    check("rst_mid_comb", 32'(comb_o[1]), 32'hF8);
    cyc(); idle(); icache_miss = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_pending", 32'(pend1), 32'd0);
    check("rst_mid_state", 32'(state1), 32'd0);
    check("rst_mid_stall_cnt", 32'(stall1), 32'd0);
    cyc(); idle();

    // Randomised traffic; second half runs without reset so counters saturate
    im = 1'b0;
    dm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n = (i >= 1500) || ($urandom_range(0, 149) != 0);
      im = im ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      dm = dm ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 11) == 0);
      icache_miss      = im;
      dcache_miss      = dm;
      id_ex_mem_read   = ($urandom_range(0, 3) == 0);
      id_ex_reg_write  = 1'($urandom);
      ex_mem_reg_write = 1'($urandom);
      id_ex_rd         = 4'($urandom_range(0, 4));
      ex_mem_rd        = 4'($urandom_range(0, 4));
      if_id_rs         = 4'($urandom_range(0, 4));
      if_id_rt         = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      if_id_uses_rt    = 1'($urandom);
      if_id_branch     = ($urandom_range(0, 2) == 0);
      if_id_branchr    = ($urandom_range(0, 4) == 0);
      if_id_cond       = 3'($urandom);
      id_ex_flag_en    = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      ex_mem_flag_en   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      branch_taken     = 1'($urandom);
    end
    cyc(); idle();
    @(negedge clk);
    check("sat_stall_d1", 32'(stall1), 32'd31);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
